// File: rtl/semaforo_pkg.sv
// Shared types and default phase durations for the semaforo traffic-light controller.
// Build option NIGHT_BLINK_EN (macro) enables the NIGHT phase in semaforo_ctrl.
package semaforo_pkg;

    typedef enum logic [1:0] {
        PARE    = 2'd0,
        SIGA    = 2'd1,
        ATENCAO = 2'd2,
        NIGHT   = 2'd3
    } phase_t;

    localparam int unsigned T_PARE_DEF    = 8;
    localparam int unsigned T_SIGA_DEF    = 6;
    localparam int unsigned T_ATENCAO_DEF = 2;
    localparam int unsigned T_BLINK_DEF   = 1;

    // Counter load value on entry to a phase: a phase of T ticks starts at T-1.
    function automatic int unsigned phase_duration(
        input phase_t      p,
        input int unsigned t_pare,
        input int unsigned t_siga,
        input int unsigned t_atencao,
        input int unsigned t_blink
    );
        int unsigned result;
        case (p)
            PARE:    result = t_pare - 1;
            SIGA:    result = t_siga - 1;
            ATENCAO: result = t_atencao - 1;
            default: result = t_blink - 1;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/semaforo_ctrl_phase_counter.sv
// Loadable CW-bit down-counter with tick enable; load wins over counting and ignores tick.
module phase_counter #(
    parameter int unsigned    CW        = 4,
    parameter logic [CW-1:0]  RESET_VAL = '0
) (
    input  logic          clk_2,
    input  logic          reset,
    input  logic          tick,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] count,
    output logic          zero
);

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            count <= RESET_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/semaforo_ctrl.sv
// Traffic-light phase sequencer PARE -> SIGA -> ATENCAO with pedestrian shortening of SIGA.
// Define NIGHT_BLINK_EN to add the NIGHT phase (blinking atencao while night=1).
module semaforo_ctrl
    import semaforo_pkg::*;
#(
    parameter int unsigned CW        = 4,
    parameter int unsigned T_PARE    = T_PARE_DEF,
    parameter int unsigned T_SIGA    = T_SIGA_DEF,
    parameter int unsigned T_ATENCAO = T_ATENCAO_DEF,
    parameter int unsigned T_BLINK   = T_BLINK_DEF
) (
    input  logic          clk_2,
    input  logic          reset,
    input  logic          tick,
    input  logic          ped_req,
    input  logic          night,
    output logic          pare,
    output logic          atencao,
    output logic          siga,
    output logic [CW-1:0] remaining,
    output logic          phase_done,
    output logic          ped_pending
);

    localparam logic [CW-1:0] PARE_LOAD = CW'(T_PARE - 1);

    phase_t        state, state_next;
    logic          load;
    logic [CW-1:0] load_val;
    logic          zero;
    logic          done_next;
    logic          pend_next;
    logic          blink_next;
    logic          atencao_next;

    function automatic logic [CW-1:0] reload(input phase_t p);
        return CW'(phase_duration(p, T_PARE, T_SIGA, T_ATENCAO, T_BLINK));
    endfunction

    function automatic phase_t successor(input phase_t p);
        case (p)
            PARE:    return SIGA;
            SIGA:    return ATENCAO;
            default: return PARE;
        endcase
    endfunction

    phase_counter #(.CW(CW), .RESET_VAL(PARE_LOAD)) u_counter (
        .clk_2    (clk_2),
        .reset    (reset),
        .tick     (tick),
        .load     (load),
        .load_val (load_val),
        .count    (remaining),
        .zero     (zero)
    );

    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_val   = '0;
        done_next  = 1'b0;
        blink_next = atencao;
        case (state)
            PARE, SIGA, ATENCAO: begin
                if (tick) begin
`ifdef NIGHT_BLINK_EN
                    if (night) begin
                        state_next = NIGHT;
                        load       = 1'b1;
                        load_val   = reload(NIGHT);
                        done_next  = 1'b1;
                    end else
`endif
                    if (zero) begin
                        state_next = successor(state);
                        load       = 1'b1;
                        load_val   = reload(successor(state));
                        done_next  = 1'b1;
                    end else if ((state == SIGA) && ped_pending && (remaining > CW'(1))) begin
                        // Force the counter to zero so SIGA ends on the following tick.
                        load     = 1'b1;
                        load_val = '0;
                    end
                end
            end
`ifdef NIGHT_BLINK_EN
            NIGHT: begin
                if (tick) begin
                    if (!night) begin
                        state_next = PARE;
                        load       = 1'b1;
                        load_val   = reload(PARE);
                        done_next  = 1'b1;
                    end else if (zero) begin
                        load       = 1'b1;
                        load_val   = reload(NIGHT);
                        blink_next = ~atencao;
                    end
                end
            end
`endif
            default: begin
                state_next = PARE;
                load       = 1'b1;
                load_val   = reload(PARE);
            end
        endcase
    end

    always_comb begin
        atencao_next = (state_next == ATENCAO);
        pend_next    = ped_pending | ped_req;
        if ((state_next == PARE) && (state != PARE)) begin
            pend_next = 1'b0;
        end
`ifdef NIGHT_BLINK_EN
        if (state_next == NIGHT) begin
            atencao_next = (state == NIGHT) ? blink_next : 1'b1;
            pend_next    = 1'b0;
        end
`endif
    end

`ifndef NIGHT_BLINK_EN
    logic unused_night;
    assign unused_night = night;
`endif

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state       <= PARE;
            pare        <= 1'b1;
            atencao     <= 1'b0;
            siga        <= 1'b0;
            phase_done  <= 1'b0;
            ped_pending <= 1'b0;
        end else begin
            state       <= state_next;
            pare        <= (state_next == PARE);
            atencao     <= atencao_next;
            siga        <= (state_next == SIGA);
            phase_done  <= done_next;
            ped_pending <= pend_next;
        end
    end

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Directed and random checks for semaforo_ctrl with default parameters.
// NIGHT_BLINK_EN additionally exercises the night-mode blink sequence.
module tb_semaforo_ctrl;

    localparam int CW = 4;
    localparam logic [2:0] PH_P = 3'b100;  // {pare, atencao, siga}
    localparam logic [2:0] PH_A = 3'b010;
    localparam logic [2:0] PH_S = 3'b001;
    localparam logic [2:0] PH_0 = 3'b000;

    logic          clk_2 = 1'b0;
    logic          reset;
    logic          tick;
    logic          ped_req;
    logic          night;
    logic          pare, atencao, siga;
    logic [CW-1:0] remaining;
    logic          phase_done;
    logic          ped_pending;

    int n_total = 0;
    int n_bad   = 0;

    semaforo_ctrl #(.CW(CW)) dut (
        .clk_2       (clk_2),
        .reset       (reset),
        .tick        (tick),
        .ped_req     (ped_req),
        .night       (night),
        .pare        (pare),
        .atencao     (atencao),
        .siga        (siga),
        .remaining   (remaining),
        .phase_done  (phase_done),
        .ped_pending (ped_pending)
    );

    always #5 clk_2 = ~clk_2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [2:0] ph, input int rem,
                             input logic done, input logic pend);
        check({tag, ".phase"}, 32'({pare, atencao, siga}), 32'(ph));
        check({tag, ".remaining"}, 32'(remaining), 32'(rem));
        check({tag, ".phase_done"}, 32'(phase_done), 32'(done));
        check({tag, ".ped_pending"}, 32'(ped_pending), 32'(pend));
    endtask

    // Drive inputs on the falling edge, sample shortly after the next rising edge.
    task automatic step(input logic t, input logic p, input logic n);
        @(negedge clk_2);
        tick    = t;
        ped_req = p;
        night   = n;
        @(posedge clk_2);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_2);
        reset   = 1'b1;
        tick    = 1'b0;
        ped_req = 1'b0;
        night   = 1'b0;
        repeat (2) @(posedge clk_2);
        @(negedge clk_2);
        reset = 1'b0;
    endtask

    initial begin
        logic [2:0] ph;
        int         lim;

        reset   = 1'b1;
        tick    = 1'b0;
        ped_req = 1'b0;
        night   = 1'b0;
        repeat (2) @(posedge clk_2);
        #1;
        check_out("in_reset", PH_P, 7, 1'b0, 1'b0);
        @(negedge clk_2);
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        check_out("after_reset", PH_P, 7, 1'b0, 1'b0);

        // Full default cycle: 8 ticks PARE, 6 SIGA, 2 ATENCAO.
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 1'b0, 1'b0);
            if (k < 8)        check_out("cycle", PH_P, 7 - k, 1'b0, 1'b0);
            else if (k == 8)  check_out("cycle", PH_S, 5, 1'b1, 1'b0);
            else if (k < 14)  check_out("cycle", PH_S, 13 - k, 1'b0, 1'b0);
            else if (k == 14) check_out("cycle", PH_A, 1, 1'b1, 1'b0);
            else if (k == 15) check_out("cycle", PH_A, 0, 1'b0, 1'b0);
            else              check_out("cycle", PH_P, 7, 1'b1, 1'b0);
        end

        // Pedestrian request latched in PARE shortens SIGA to two ticks.
        step(1'b0, 1'b1, 1'b0);
        check_out("ped_latch", PH_P, 7, 1'b0, 1'b1);
        for (int k = 1; k <= 7; k++) step(1'b1, 1'b0, 1'b0);
        check_out("ped_pare_end", PH_P, 0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        check_out("ped_siga_entry", PH_S, 5, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        check_out("ped_shorten", PH_S, 0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        check_out("ped_atencao", PH_A, 1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        check_out("ped_atencao_end", PH_A, 0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        check_out("ped_clear_wins", PH_P, 7, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check_out("ped_cleared", PH_P, 7, 1'b0, 1'b0);

        // Freeze mid-SIGA with remaining=3.
        for (int k = 1; k <= 8; k++) step(1'b1, 1'b0, 1'b0);
        check_out("frz_siga", PH_S, 5, 1'b1, 1'b0);
        repeat (2) step(1'b1, 1'b0, 1'b0);
        check_out("frz_start", PH_S, 3, 1'b0, 1'b0);
        for (int k = 0; k < 50; k++) begin
            step(1'b0, 1'b0, 1'b0);
            check_out("frz_hold", PH_S, 3, 1'b0, 1'b0);
        end

        // Asynchronous reset between edges during ATENCAO.
        repeat (4) step(1'b1, 1'b0, 1'b0);
        check_out("ar_atencao", PH_A, 1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check_out("ar_pend", PH_A, 1, 1'b0, 1'b1);
        @(negedge clk_2);
        ped_req = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_out("ar_async", PH_P, 7, 1'b0, 1'b0);
        @(negedge clk_2);
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        check_out("ar_release", PH_P, 7, 1'b0, 1'b0);

        // Random tick/ped_req: one-hot phase and bounded remaining.
        for (int k = 0; k < 10000; k++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), 1'b0);
            ph = {pare, atencao, siga};
            check("rnd_onehot", 32'($countones(ph)), 32'd1);
            lim = pare ? 7 : (siga ? 5 : 1);
            check("rnd_rem_bound", 32'(int'(remaining) <= lim), 32'd1);
        end

`ifdef NIGHT_BLINK_EN
        do_reset();
        step(1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) step(1'b1, 1'b0, 1'b0);
        check_out("nt_siga", PH_S, 5, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check_out("nt_enter", PH_A, 0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check_out("nt_blink0", PH_0, 0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check_out("nt_blink1", PH_A, 0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        check_out("nt_ped_held", PH_A, 0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check_out("nt_exit", PH_P, 7, 1'b1, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
